instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Encodes LEGv8-style instruction fields (D-type LDUR/STUR, CB-type CBZ,
// R-type ADD/SUB/AND/ORR) into 32-bit words and writes them one at a time
// into consecutive instruction-memory locations starting at address 0.
//
// Handshake: a request is accepted on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is only high in IDLE with clear low (and
// reset released), so at most one request is in flight; the write follows
// in the next cycle, giving one word per two cycles.
//
// Parameters:
//   DEPTH   - number of words that may be written (must be <= 2**ADDR_W)
//   ADDR_W  - instruction-memory address width
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - request present on op_sel/rd/rn/rm/imm
//   in_ready   - request accepted this cycle if in_valid is high
//   op_sel     - 0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal
//   rd         - Rd (R-type) or Rt (D/CB-type)
//   rn, rm     - source registers
//   imm        - [8:0] DT_address (D-type), [18:0] offset (CB-type)
//   clear      - synchronous restart of pointer, count and err
//   imem_we    - instruction-memory write enable (high only in WRITE)
//   imem_addr  - write address (current pointer)
//   imem_wdata - encoded word
//   count      - words written so far
//   full       - count == DEPTH
//   err        - sticky: an illegal op_sel was accepted
//   state_dbg  - FSM state (0 IDLE, 1 WRITE, 2 FULL)
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [18:0]       imm,
    input  logic              clear,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic [31:0]         word_q, word_d;
    logic [31:0]         enc;
    logic                accept;

    // Field encoder: each format only picks up the inputs it uses.
    always_comb begin
        enc = 32'h0;
        case (op_sel)
            3'd0:    enc = {11'h7C2, imm[8:0], 2'b00, rn, rd};
            3'd1:    enc = {11'h7C0, imm[8:0], 2'b00, rn, rd};
            3'd2:    enc = {8'hB4, imm, rd};
            3'd3:    enc = {11'h458, rm, 6'b0, rn, rd};
            3'd4:    enc = {11'h658, rm, 6'b0, rn, rd};
            3'd5:    enc = {11'h450, rm, 6'b0, rn, rd};
            3'd6:    enc = {11'h550, rm, 6'b0, rn, rd};
            default: enc = 32'h0;
        endcase
    end

    // reset is included so in_ready is 0 while reset is held, even though
    // the state register already reads IDLE.
    assign in_ready = reset && (state_q == IDLE) && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        word_d  = word_q;
        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_sel == 3'd7) begin
                            err_d = 1'b1;
                        end else begin
                            word_d  = enc;
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    state_d = (count_d == DEPTH_C) ? FULL : IDLE;
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            word_q  <= word_d;
        end
    end

    // clear aborts a pending write in the same cycle.
    assign imem_we    = (state_q == WRITE) && !clear;
    assign imem_addr  = ptr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule
